// File: rtl/uart_rx_os16.sv
// 16x-oversampling 8N1 UART receiver: pin synchroniser, start-bit validation,
// 3-sample majority vote per bit, stop-bit check with valid / framing-error pulses.
module uart_rx_os16 #(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 115_200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       dvalid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned DIV      = CLK_HZ / (BAUD * 16);
    localparam int unsigned CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned DIV_LAST = (DIV > 0) ? DIV - 1 : 0;

    if (DIV < 1) begin : g_div_check
        $error("uart_rx_os16: CLK_HZ/(BAUD*16) must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               rx_m;
    logic               rx_s;
    logic [CNT_W-1:0]   div_cnt;
    logic               tick;
    logic [3:0]         samp;
    logic [2:0]         bit_idx;
    logic               v7;
    logic               v8;
    logic               vote;
    logic               mid;
    logic               last;
    logic [7:0]         shift;
    logic               dvalid_c;
    logic               frame_err_c;

    // Two-flop synchroniser; idle level is high
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // Free-running 16x baud tick
    assign tick = (div_cnt == CNT_W'(DIV_LAST));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

    assign mid  = tick && (samp == 4'd9);
    assign last = tick && (samp == 4'd15);
    // Majority of samples 7, 8 and the live sample at 9
    assign vote = (v7 & v8) | (v7 & rx_s) | (v8 & rx_s);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (tick && !rx_s) state_nxt = S_START;
            S_START: begin
                if (mid && vote) begin
                    state_nxt = S_IDLE;
                end else if (last) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA:  if (last && (bit_idx == 3'd7)) state_nxt = S_STOP;
            S_STOP:  if (mid) state_nxt = vote ? S_IDLE : S_BREAK;
            S_BREAK: if (tick && rx_s) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        dvalid_c    = 1'b0;
        frame_err_c = 1'b0;
        if ((state == S_STOP) && mid) begin
            dvalid_c    = vote;
            frame_err_c = !vote;
        end
    end

    // Sample index, bit counter, vote samples and shift register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            samp    <= '0;
            bit_idx <= '0;
            v7      <= 1'b0;
            v8      <= 1'b0;
            shift   <= '0;
        end else begin
            if (state == S_IDLE) begin
                samp <= '0;
            end else if (tick) begin
                samp <= samp + 4'd1;
            end
            if (state == S_START) begin
                bit_idx <= '0;
            end else if ((state == S_DATA) && last) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if ((state != S_IDLE) && tick && (samp == 4'd7)) v7 <= rx_s;
            if ((state != S_IDLE) && tick && (samp == 4'd8)) v8 <= rx_s;
            if ((state == S_DATA) && mid) shift <= {vote, shift[7:1]};
        end
    end

    // Registered outputs; busy tracks the state being entered
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_data   <= '0;
            dvalid    <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            dvalid    <= dvalid_c;
            frame_err <= frame_err_c;
            busy      <= (state_nxt != S_IDLE);
            if (dvalid_c) rx_data <= shift;
        end
    end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16 at 16 clocks per bit (DIV=1).
// Stimulus changes on falling edges; outputs are observed on falling edges.
module tb_uart_rx_os16;

    logic       clock = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] rx_data;
    logic       dvalid;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int dv_cnt = 0;
    int fe_cnt = 0;
    int both_cnt = 0;
    int busy_cyc = 0;
    logic [7:0] dq[$];

    always #5 clock = ~clock;

    uart_rx_os16 #(.CLK_HZ(1_600_000), .BAUD(100_000)) dut (
        .clock(clock),
        .reset(reset),
        .rx(rx),
        .rx_data(rx_data),
        .dvalid(dvalid),
        .frame_err(frame_err),
        .busy(busy)
    );

    // Pulse monitor
    always @(negedge clock) begin
        if (!reset) begin
            if (dvalid) begin
                dv_cnt = dv_cnt + 1;
                dq.push_back(rx_data);
            end
            if (frame_err) fe_cnt = fe_cnt + 1;
            if (dvalid && frame_err) both_cnt = both_cnt + 1;
            if (busy) busy_cyc = busy_cyc + 1;
        end
    end

    task automatic drive(input logic b, input int n);
        rx = b;
        repeat (n) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        drive(1'b0, 16);
        for (int i = 0; i < 8; i++) drive(d[i], 16);
        drive(stop_bit, 16);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx = 1'b1;
        repeat (3) @(negedge clock);
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %0h exp 0", rx_data); end
        checks++; if (dvalid !== 1'b0) begin errors++; $display("FAIL reset_dvalid got %0b exp 0", dvalid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %0b exp 0", frame_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        reset = 1'b0;
        drive(1'b1, 10);
    endtask

    task automatic test_byte();
        int dv0, fe0;
        dv0 = dv_cnt; fe0 = fe_cnt;
        send_frame(8'h55, 1'b1);
        drive(1'b1, 4);
        checks++; if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL byte_dvalid_count got %0d exp 1", dv_cnt - dv0); end
        checks++; if (rx_data !== 8'h55) begin errors++; $display("FAIL byte_rx_data got %0h exp 55", rx_data); end
        checks++; if (fe_cnt != fe0) begin errors++; $display("FAIL byte_frame_err got %0d exp 0", fe_cnt - fe0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL byte_busy_after got %0b exp 0", busy); end
    endtask

    task automatic test_false_start();
        int dv0, fe0, b0, n;
        dv0 = dv_cnt; fe0 = fe_cnt; b0 = busy_cyc;
        drive(1'b0, 4);
        drive(1'b1, 40);
        n = busy_cyc - b0;
        checks++; if (dv_cnt != dv0) begin errors++; $display("FAIL false_start_dvalid got %0d exp 0", dv_cnt - dv0); end
        checks++; if (fe_cnt != fe0) begin errors++; $display("FAIL false_start_frame_err got %0d exp 0", fe_cnt - fe0); end
        checks++; if (n < 1 || n > 12) begin errors++; $display("FAIL false_start_busy_cycles got %0d exp 1..12", n); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL false_start_busy_end got %0b exp 0", busy); end
    endtask

    task automatic test_frame_err();
        int dv0, fe0;
        dv0 = dv_cnt; fe0 = fe_cnt;
        send_frame(8'hA3, 1'b0);
        drive(1'b0, 16);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL break_busy got %0b exp 1", busy); end
        drive(1'b0, 16);
        drive(1'b1, 20);
        checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL ferr_count got %0d exp 1", fe_cnt - fe0); end
        checks++; if (dv_cnt != dv0) begin errors++; $display("FAIL ferr_dvalid got %0d exp 0", dv_cnt - dv0); end
        checks++; if (rx_data !== 8'h55) begin errors++; $display("FAIL ferr_rx_data_held got %0h exp 55", rx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_released got %0b exp 0", busy); end
        send_frame(8'h3C, 1'b1);
        drive(1'b1, 8);
        checks++; if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL after_ferr_dvalid got %0d exp 1", dv_cnt - dv0); end
        checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL after_ferr_rx_data got %0h exp 3c", rx_data); end
    endtask

    task automatic test_back_to_back();
        int dv0, q0;
        logic [7:0] a, b;
        dv0 = dv_cnt; q0 = dq.size();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        drive(1'b1, 8);
        a = (dq.size() > q0) ? dq[q0] : 8'hxx;
        b = (dq.size() > q0 + 1) ? dq[q0 + 1] : 8'hxx;
        checks++; if (dv_cnt - dv0 !== 2) begin errors++; $display("FAIL b2b_dvalid_count got %0d exp 2", dv_cnt - dv0); end
        checks++; if (a !== 8'h00) begin errors++; $display("FAIL b2b_first got %0h exp 00", a); end
        checks++; if (b !== 8'hFF) begin errors++; $display("FAIL b2b_second got %0h exp ff", b); end
        checks++; if (rx_data !== 8'hFF) begin errors++; $display("FAIL b2b_rx_data got %0h exp ff", rx_data); end
    endtask

    task automatic test_spike();
        int dv0;
        logic [7:0] d;
        d = 8'h0F;
        dv0 = dv_cnt;
        drive(1'b0, 16);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                // Bit-time offset 9 is the value seen by the s=8 sample
                drive(d[i], 9);
                drive(!d[i], 1);
                drive(d[i], 6);
            end else begin
                drive(d[i], 16);
            end
        end
        drive(1'b1, 16);
        drive(1'b1, 8);
        checks++; if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL spike_dvalid got %0d exp 1", dv_cnt - dv0); end
        checks++; if (rx_data !== 8'h0F) begin errors++; $display("FAIL spike_rx_data got %0h exp 0f", rx_data); end
    endtask

    task automatic test_reset_mid();
        int dv0, fe0;
        logic [7:0] d;
        d = 8'hF0;
        drive(1'b0, 16);
        for (int i = 0; i < 4; i++) drive(d[i], 16);
        drive(d[4], 8);
        dv0 = dv_cnt; fe0 = fe_cnt;
        reset = 1'b1;
        #1;
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL midreset_rx_data got %0h exp 0", rx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %0b exp 0", busy); end
        checks++; if (dvalid !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL midreset_pulses got %0b%0b exp 00", dvalid, frame_err); end
        @(negedge clock);
        rx = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        drive(1'b1, 200);
        checks++; if (dv_cnt != dv0 || fe_cnt != fe0) begin errors++; $display("FAIL midreset_no_pulse got %0d/%0d exp 0/0", dv_cnt - dv0, fe_cnt - fe0); end
        send_frame(8'h81, 1'b1);
        drive(1'b1, 8);
        checks++; if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL midreset_next_dvalid got %0d exp 1", dv_cnt - dv0); end
        checks++; if (rx_data !== 8'h81) begin errors++; $display("FAIL midreset_next_rx_data got %0h exp 81", rx_data); end
    endtask

    initial begin
        reset = 1'b1;
        rx = 1'b1;
        @(negedge clock);
        test_reset();
        test_byte();
        test_false_start();
        test_frame_err();
        test_back_to_back();
        test_spike();
        test_reset_mid();
        checks++; if (both_cnt != 0) begin errors++; $display("FAIL exclusive_pulses got %0d exp 0", both_cnt); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
